// File: rtl/psum_binarize_pack.sv
// Reads a layer's fp16 partial sums from the accumulation memory, thresholds each
// sum into one activation bit, and streams LSB-first packed words on valid/ready.
module psum_binarize_pack #(
    parameter int WORD_W = 32,
    parameter int ADDR_W = 11
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    input  logic [ADDR_W-1:0] address_start,
    input  logic [ADDR_W-1:0] count,
    input  logic [15:0]       thresh,
    output logic              mem_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [15:0]       mem_dout,
    output logic [WORD_W-1:0] m_tdata,
    output logic              m_tvalid,
    input  logic              m_tready,
    output logic              m_tlast,
    output logic              busy,
    output logic              done
);

    localparam int CNT_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t            state_r;
    state_t            state_s;
    logic [ADDR_W-1:0] addr_base_r;
    logic [ADDR_W-1:0] count_r;
    logic [15:0]       thresh_r;
    logic [ADDR_W-1:0] rd_idx_r;
    logic              rd_valid_r;
    logic [ADDR_W-1:0] elem_idx_r;
    logic [WORD_W-1:0] pack_r;
    logic [CNT_W-1:0]  pack_cnt_r;
    logic [WORD_W-1:0] out_data_r;
    logic              out_valid_r;
    logic              out_last_r;
    logic              done_r;

    logic              stall_s;
    logic              issue_s;
    logic              accept_s;
    logic              last_read_s;
    logic              bit_s;
    logic              final_elem_s;
    logic              word_full_s;
    logic              word_close_s;
    logic [WORD_W-1:0] word_s;

    // Signed zero collapses to +0; the key maps fp16 total order onto unsigned order.
    function automatic logic [15:0] fp16_key(input logic [15:0] x);
        logic [15:0] xn;
        xn = (x[14:0] == 15'h0000) ? 16'h0000 : x;
        return xn[15] ? ~xn : (xn | 16'h8000);
    endfunction

    function automatic logic fp16_ge(input logic [15:0] a, input logic [15:0] b);
        return fp16_key(a) >= fp16_key(b);
    endfunction

    assign stall_s      = out_valid_r && !m_tready;
    assign issue_s      = (state_r == READ) && !stall_s;
    assign accept_s     = out_valid_r && m_tready;
    assign last_read_s  = (rd_idx_r == (count_r - ADDR_W'(1)));
    assign bit_s        = fp16_ge(mem_dout, thresh_r);
    assign final_elem_s = (elem_idx_r == (count_r - ADDR_W'(1)));
    assign word_full_s  = (pack_cnt_r == CNT_W'(WORD_W - 1));
    assign word_close_s = rd_valid_r && (word_full_s || final_elem_s);
    assign word_s       = pack_r | ({{(WORD_W-1){1'b0}}, bit_s} << pack_cnt_r);

    // State register.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start && (count != {ADDR_W{1'b0}})) begin
                    state_s = READ;
                end else begin
                    state_s = IDLE;
                end
            end
            READ: begin
                if (issue_s && last_read_s) begin
                    state_s = DRAIN;
                end else begin
                    state_s = READ;
                end
            end
            DRAIN: begin
                if (accept_s && out_last_r) begin
                    state_s = IDLE;
                end else begin
                    state_s = DRAIN;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // Memory read port and busy; reads must react to backpressure in the same cycle.
    always_comb begin
        mem_en   = 1'b0;
        mem_addr = {ADDR_W{1'b0}};
        busy     = 1'b0;
        case (state_r)
            READ: begin
                busy = 1'b1;
                if (issue_s) begin
                    mem_en   = 1'b1;
                    mem_addr = addr_base_r + rd_idx_r;
                end else begin
                    mem_en   = 1'b0;
                    mem_addr = {ADDR_W{1'b0}};
                end
            end
            DRAIN:   busy = 1'b1;
            IDLE:    busy = 1'b0;
            default: busy = 1'b0;
        endcase
    end

    // Pass parameters, read index and read-data pipeline flag.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            addr_base_r <= {ADDR_W{1'b0}};
            count_r     <= {ADDR_W{1'b0}};
            thresh_r    <= 16'h0000;
            rd_idx_r    <= {ADDR_W{1'b0}};
            rd_valid_r  <= 1'b0;
        end else begin
            rd_valid_r <= issue_s;
            if ((state_r == IDLE) && start) begin
                addr_base_r <= address_start;
                count_r     <= count;
                thresh_r    <= thresh;
                rd_idx_r    <= {ADDR_W{1'b0}};
            end else if (issue_s) begin
                rd_idx_r <= rd_idx_r + ADDR_W'(1);
            end
        end
    end

    // Bit packing; a closing word hands off to the output register on the same edge.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            elem_idx_r <= {ADDR_W{1'b0}};
            pack_r     <= {WORD_W{1'b0}};
            pack_cnt_r <= {CNT_W{1'b0}};
        end else if ((state_r == IDLE) && start) begin
            elem_idx_r <= {ADDR_W{1'b0}};
            pack_r     <= {WORD_W{1'b0}};
            pack_cnt_r <= {CNT_W{1'b0}};
        end else if (rd_valid_r) begin
            elem_idx_r <= elem_idx_r + ADDR_W'(1);
            if (word_close_s) begin
                pack_r     <= {WORD_W{1'b0}};
                pack_cnt_r <= {CNT_W{1'b0}};
            end else begin
                pack_r     <= word_s;
                pack_cnt_r <= pack_cnt_r + CNT_W'(1);
            end
        end
    end

    // Output register and done pulse.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            out_data_r  <= {WORD_W{1'b0}};
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            if (word_close_s) begin
                out_data_r  <= word_s;
                out_valid_r <= 1'b1;
                out_last_r  <= final_elem_s;
            end else if (accept_s) begin
                out_data_r  <= {WORD_W{1'b0}};
                out_valid_r <= 1'b0;
                out_last_r  <= 1'b0;
            end
            done_r <= ((state_r == IDLE) && start && (count == {ADDR_W{1'b0}})) ||
                      ((state_r == DRAIN) && accept_s && out_last_r);
        end
    end

    assign m_tdata  = out_data_r;
    assign m_tvalid = out_valid_r;
    assign m_tlast  = out_last_r;
    assign done     = done_r;

endmodule

// File: tb/tb_psum_binarize_pack.sv
// Directed bench for psum_binarize_pack with a memory model and an expected-word scoreboard.
module tb_psum_binarize_pack;

    localparam int WORD_W = 32;
    localparam int ADDR_W = 11;

    logic              clk = 1'b0;
    logic              resetn;
    logic              start;
    logic [ADDR_W-1:0] address_start;
    logic [ADDR_W-1:0] count;
    logic [15:0]       thresh;
    logic              mem_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [15:0]       mem_dout = 16'h0000;
    logic [WORD_W-1:0] m_tdata;
    logic              m_tvalid;
    logic              m_tready;
    logic              m_tlast;
    logic              busy;
    logic              done;

    logic [15:0] mem [0:2047];
    logic [32:0] exp_q [$];
    logic [31:0] got_q [$];
    int total  = 0;
    int passed = 0;
    int failed = 0;

    always #5 clk = ~clk;

    psum_binarize_pack #(.WORD_W(WORD_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .resetn(resetn), .start(start), .address_start(address_start),
        .count(count), .thresh(thresh), .mem_en(mem_en), .mem_addr(mem_addr),
        .mem_dout(mem_dout), .m_tdata(m_tdata), .m_tvalid(m_tvalid),
        .m_tready(m_tready), .m_tlast(m_tlast), .busy(busy), .done(done)
    );

    // One-cycle-latency read port of the partial-sum memory.
    always @(posedge clk) begin
        if (mem_en) mem_dout <= mem[mem_addr];
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    // Sign/magnitude reference for value >= threshold.
    function automatic logic ref_ge(input logic [15:0] v, input logic [15:0] t);
        logic        vs, ts;
        logic [14:0] vm, tm;
        vm = v[14:0];
        tm = t[14:0];
        vs = (vm == 15'h0000) ? 1'b0 : v[15];
        ts = (tm == 15'h0000) ? 1'b0 : t[15];
        if (vs != ts) return ts;
        if (!vs) return vm >= tm;
        return vm <= tm;
    endfunction

    function automatic logic [15:0] rand_fp16();
        logic [15:0] v;
        v = 16'($urandom);
        if (v[14:10] == 5'h1F) v[14] = 1'b0;
        return v;
    endfunction

    task automatic build_exp(input logic [10:0] as, input int cnt, input logic [15:0] th);
        logic [31:0] w;
        logic [10:0] a;
        w = 32'h0;
        exp_q.delete();
        got_q.delete();
        for (int k = 0; k < cnt; k++) begin
            a = as + 11'(k);
            if (ref_ge(mem[a], th)) w[k % WORD_W] = 1'b1;
            if ((k % WORD_W == WORD_W - 1) || (k == cnt - 1)) begin
                exp_q.push_back({(k == cnt - 1), w});
                w = 32'h0;
            end
        end
    endtask

    task automatic run_pass(input logic [10:0] as, input int cnt, input logic [15:0] th,
                            input int mode, input int poke_c, input int exp_done_c);
        int          c;
        int          exp_rd;
        logic        prev_stall;
        logic [31:0] prev_data;
        logic        prev_last;
        logic        seen_done;
        logic [32:0] e;
        logic [10:0] ea;
        build_exp(as, cnt, th);
        m_tready      = 1'b1;
        address_start = as;
        count         = 11'(cnt);
        thresh        = th;
        start         = 1'b1;
        @(posedge clk); #1;
        start      = 1'b0;
        c          = 0;
        exp_rd     = 0;
        prev_stall = 1'b0;
        prev_data  = 32'h0;
        prev_last  = 1'b0;
        seen_done  = 1'b0;
        while (!seen_done && c < 2000) begin
            start    = 1'b0;
            m_tready = (mode == 1) ? (((c / 3) % 2) == 1) : 1'b1;
            if (c == poke_c) begin
                start         = 1'b1;
                address_start = 11'd100;
                count         = 11'd3;
                thresh        = 16'h0000;
            end
            #1;
            if (prev_stall) begin
                check("hold_valid", m_tvalid, 1);
                check("hold_data", m_tdata, prev_data);
                check("hold_last", m_tlast, prev_last);
            end
            if (m_tvalid && !m_tready) check("stall_mem_en", mem_en, 0);
            if (mem_en) begin
                ea = as + 11'(exp_rd);
                check("mem_addr", mem_addr, ea);
                exp_rd++;
            end
            if (m_tvalid && m_tready) begin
                check("word_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("word_data", m_tdata, e[31:0]);
                    check("word_last", m_tlast, e[32]);
                end
                got_q.push_back(m_tdata);
            end
            if (done) begin
                seen_done = 1'b1;
                check("done_busy_low", busy, 0);
                if (exp_done_c >= 0) check("done_cycle", c, exp_done_c);
            end else begin
                check("busy_in_pass", busy, 1);
            end
            prev_stall = m_tvalid && !m_tready;
            prev_data  = m_tdata;
            prev_last  = m_tlast;
            @(posedge clk); #1;
            c++;
        end
        start    = 1'b0;
        m_tready = 1'b1;
        check("done_seen", seen_done, 1);
        check("reads_issued", exp_rd, cnt);
        check("queue_drained", exp_q.size(), 0);
    endtask

    task automatic idle_check(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            check("idle_valid", m_tvalid, 0);
            check("idle_busy", busy, 0);
            check("idle_mem_en", mem_en, 0);
        end
    endtask

    initial begin
        resetn        = 1'b0;
        start         = 1'b0;
        address_start = 11'd0;
        count         = 11'd0;
        thresh        = 16'h0000;
        m_tready      = 1'b1;
        for (int i = 0; i < 2048; i++) mem[i] = 16'h0000;
        repeat (3) @(posedge clk);
        #1;
        check("rst_mem_en", mem_en, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_tvalid", m_tvalid, 0);
        check("rst_tdata", m_tdata, 0);
        check("rst_tlast", m_tlast, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        resetn = 1'b1;
        @(posedge clk); #1;

        // Alternating +1/-1 against +0.
        for (int i = 0; i < 32; i++) mem[i] = (i % 2 == 0) ? 16'h3C00 : 16'hBC00;
        run_pass(11'd0, 32, 16'h0000, 0, -1, 34);
        check("t1_words", got_q.size(), 1);
        check("t1_word0", got_q[0], 32'h55555555);

        // Step from 1.0 to 3.0 against 2.0 over two words.
        for (int i = 0; i < 40; i++) mem[i] = (i < 20) ? 16'h3C00 : 16'h4200;
        run_pass(11'd0, 40, 16'h4000, 0, -1, 42);
        check("t2_words", got_q.size(), 2);
        check("t2_word0", got_q[0], 32'hFFF00000);
        check("t2_word1", got_q[1], 32'h000000FF);

        // Signed zeros and tiny negatives against -0.
        mem[0] = 16'h0000; mem[1] = 16'h8000; mem[2] = 16'h8001; mem[3] = 16'h0001;
        run_pass(11'd0, 4, 16'h8000, 0, -1, 6);
        check("t3_words", got_q.size(), 1);
        check("t3_word0", got_q[0], 32'h0000000B);

        // Backpressure with random non-NaN sums.
        for (int i = 0; i < 96; i++) mem[i] = rand_fp16();
        run_pass(11'd0, 96, 16'h3800, 1, -1, -1);
        check("t4_words", got_q.size(), 3);

        // Address wrap, with an ignored start while busy.
        for (int i = 2040; i < 2048; i++) mem[i] = rand_fp16();
        for (int i = 0; i < 8; i++) mem[i] = rand_fp16();
        mem[100] = 16'h3C00; mem[101] = 16'h3C00; mem[102] = 16'h3C00;
        run_pass(11'd2040, 16, 16'h0000, 0, 5, 18);
        check("t5_words", got_q.size(), 1);
        idle_check(4);

        // Zero-length pass.
        count = 11'd0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("zero_done", done, 1);
        check("zero_busy", busy, 0);
        check("zero_valid", m_tvalid, 0);
        @(posedge clk); #1;
        check("zero_done_once", done, 0);
        idle_check(3);

        // Reset in the middle of a pass.
        for (int i = 0; i < 64; i++) mem[i] = rand_fp16();
        address_start = 11'd0;
        count         = 11'd64;
        thresh        = 16'h0000;
        start         = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 9; i++) begin
            check("pre_rst_mem_en", mem_en, 1);
            @(posedge clk); #1;
        end
        check("pre_rst_mem_en", mem_en, 1);
        resetn = 1'b0;
        @(posedge clk); #1;
        check("mid_rst_mem_en", mem_en, 0);
        check("mid_rst_mem_addr", mem_addr, 0);
        check("mid_rst_tvalid", m_tvalid, 0);
        check("mid_rst_tdata", m_tdata, 0);
        check("mid_rst_tlast", m_tlast, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        resetn = 1'b1;
        idle_check(5);
        for (int i = 0; i < 8; i++) mem[i] = rand_fp16();
        run_pass(11'd0, 8, 16'h0000, 0, -1, 10);
        check("t6_words", got_q.size(), 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
